// File: rtl/dpram_port_arbiter.sv
// Two-client round-robin arbiter for a dual-port RAM (one write port, one read port).
// Registers the RAM command and steers returning read data back to the client that issued it.
module dpram_port_arbiter #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c0_wr_req,
  input  logic [ADDR_SIZE-1:0] c0_wr_addr,
  input  logic [DATA_SIZE-1:0] c0_wr_data,
  output logic                 c0_wr_gnt,
  input  logic                 c1_wr_req,
  input  logic [ADDR_SIZE-1:0] c1_wr_addr,
  input  logic [DATA_SIZE-1:0] c1_wr_data,
  output logic                 c1_wr_gnt,
  input  logic                 c0_rd_req,
  input  logic [ADDR_SIZE-1:0] c0_rd_addr,
  output logic                 c0_rd_gnt,
  output logic                 c0_rd_valid,
  output logic [DATA_SIZE-1:0] c0_rd_data,
  input  logic                 c1_rd_req,
  input  logic [ADDR_SIZE-1:0] c1_rd_addr,
  output logic                 c1_rd_gnt,
  output logic                 c1_rd_valid,
  output logic [DATA_SIZE-1:0] c1_rd_data,
  output logic                 wr,
  output logic [ADDR_SIZE-1:0] addr_wr,
  output logic [DATA_SIZE-1:0] data_wr,
  output logic                 rd,
  output logic [ADDR_SIZE-1:0] addr_rd,
  input  logic [DATA_SIZE-1:0] data_rd
);

  logic                 wr_pri_reg, wr_pri_next;
  logic                 rd_pri_reg, rd_pri_next;
  logic                 wr_any, wr_both, wr_win, wr_gnt_any;
  logic                 rd_any, rd_both, rd_win, rd_gnt_any;
  logic                 collision;
  logic [ADDR_SIZE-1:0] wr_win_addr, rd_win_addr;
  logic [DATA_SIZE-1:0] wr_win_data;

  logic                 wr_reg, rd_reg;
  logic [ADDR_SIZE-1:0] addr_wr_reg, addr_rd_reg;
  logic [DATA_SIZE-1:0] data_wr_reg;

  logic [RD_LAT:0]      tag_valid_reg;
  logic [RD_LAT:0]      tag_id_reg;
  logic [1:0]           ret_valid;
  logic [DATA_SIZE-1:0] ret_data [2];

  // Arbitration: grants are purely combinational from requests, addresses and pointers.
  always_comb begin
    wr_any      = c0_wr_req | c1_wr_req;
    wr_both     = c0_wr_req & c1_wr_req;
    wr_win      = wr_both ? wr_pri_reg : c1_wr_req;
    wr_win_addr = wr_win ? c1_wr_addr : c0_wr_addr;
    wr_win_data = wr_win ? c1_wr_data : c0_wr_data;
    wr_gnt_any  = rst & wr_any;

    rd_any      = c0_rd_req | c1_rd_req;
    rd_both     = c0_rd_req & c1_rd_req;
    rd_win      = rd_both ? rd_pri_reg : c1_rd_req;
    rd_win_addr = rd_win ? c1_rd_addr : c0_rd_addr;

    // A read of the address being written this cycle waits one cycle so it sees the new data.
    collision   = wr_any & rd_any & (rd_win_addr == wr_win_addr);
    rd_gnt_any  = rst & rd_any & ~collision;

    c0_wr_gnt   = wr_gnt_any & ~wr_win;
    c1_wr_gnt   = wr_gnt_any & wr_win;
    c0_rd_gnt   = rd_gnt_any & ~rd_win;
    c1_rd_gnt   = rd_gnt_any & rd_win;

    wr_pri_next = wr_pri_reg;
    if (wr_gnt_any && wr_both) begin
      wr_pri_next = ~wr_win;
    end
    rd_pri_next = rd_pri_reg;
    if (rd_gnt_any && rd_both) begin
      rd_pri_next = ~rd_win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pri_reg <= 1'b0;
      rd_pri_reg <= 1'b0;
    end else begin
      wr_pri_reg <= wr_pri_next;
      rd_pri_reg <= rd_pri_next;
    end
  end

  // RAM command registers; addresses and data hold when no command is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_reg      <= 1'b0;
      rd_reg      <= 1'b0;
      addr_wr_reg <= '0;
      addr_rd_reg <= '0;
      data_wr_reg <= '0;
    end else begin
      wr_reg <= wr_gnt_any;
      rd_reg <= rd_gnt_any;
      if (wr_gnt_any) begin
        addr_wr_reg <= wr_win_addr;
        data_wr_reg <= wr_win_data;
      end
      if (rd_gnt_any) begin
        addr_rd_reg <= rd_win_addr;
      end
    end
  end

  assign wr      = wr_reg;
  assign rd      = rd_reg;
  assign addr_wr = addr_wr_reg;
  assign addr_rd = addr_rd_reg;
  assign data_wr = data_wr_reg;

  // Stage k is valid in cycle grant+1+k, so the last stage lines up with data_rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[RD_LAT-1:0], rd_gnt_any};
      tag_id_reg    <= {tag_id_reg[RD_LAT-1:0], rd_win};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic [DATA_SIZE-1:0] hold_reg;

      assign ret_valid[gi] = tag_valid_reg[RD_LAT] & (tag_id_reg[RD_LAT] == 1'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_reg <= '0;
        end else if (ret_valid[gi]) begin
          hold_reg <= data_rd;
        end
      end

      // Pass data_rd straight through in the valid cycle, then keep showing it.
      assign ret_data[gi] = ret_valid[gi] ? data_rd : hold_reg;
    end
  endgenerate

  assign c0_rd_valid = ret_valid[0];
  assign c1_rd_valid = ret_valid[1];
  assign c0_rd_data  = ret_data[0];
  assign c1_rd_data  = ret_data[1];

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-requester arbiter and sequencer for the dual-port RAM (independent write and read ports). Sits between two client engines and the RAM pins: wr, addr_wr, data_wr, rd, addr_rd, data_rd. It grants each RAM port to one client per cycle under round-robin and registers the RAM-side command. It routes read data back to the issuing client and stalls reads that would collide with a same-cycle write to the same address.

## Interface
- ADDR_SIZE, 4, RAM address width
- DATA_SIZE, 32, RAM data width
- RD_LAT, 1, cycles from RAM sampling rd high to data_rd valid (1..4)

Ports:
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- c0_wr_req, c1_wr_req  in  1  write request
- c0_wr_addr, c1_wr_addr  in  ADDR_SIZE  write address
- c0_wr_data, c1_wr_data  in  DATA_SIZE  write data
- c0_wr_gnt, c1_wr_gnt  out  1  write accepted this cycle (combinational)
- c0_rd_req, c1_rd_req  in  1  read request
- c0_rd_addr, c1_rd_addr  in  ADDR_SIZE  read address
- c0_rd_gnt, c1_rd_gnt  out  1  read accepted this cycle (combinational)
- c0_rd_valid, c1_rd_valid  out  1  read data valid for that client
- c0_rd_data, c1_rd_data  out  DATA_SIZE  read data, copy of data_rd
- wr, rd  out  1  RAM write/read strobes (registered)
- addr_wr, addr_rd  out  ADDR_SIZE  RAM addresses (registered)
- data_wr  out  DATA_SIZE  RAM write data (registered)
- data_rd  in  DATA_SIZE  RAM read data

## Operation
- Handshake: a request is accepted when req and gnt are both high at a posedge. The client holds req, addr and data stable until accepted. gnt depends only on reqs, addresses and arbiter state.
- Write arbiter:
  - Round-robin pointer wr_pri (reset 0).
  - One requester: it wins.
  - Both requesting: client wr_pri wins, and wr_pri flips to the loser after that grant.
  - No grant leaves the pointer unchanged.
- Read arbiter: same scheme with its own pointer rd_pri (reset 0).
- Collision stall:
  - If the read winner's address equals the write winner's address in the same cycle, the read grant is suppressed.
  - rd_pri is unchanged and the write proceeds.
  - The read is granted next cycle if no new collision occurs.
  - There is no stall on a mismatched address.
- RAM command: on an accepted write, the next cycle drives wr=1 with addr_wr/data_wr from the winner. Otherwise wr=0 and addr_wr/data_wr hold their last value. Reads behave the same for rd/addr_rd.
- Return path:
  - A tag pipeline of depth RD_LAT+1 carries {valid, client id} from read grant to data return.
  - cN_rd_valid is high exactly one cycle, the cycle data_rd is valid for that read.
  - cN_rd_data equals data_rd whenever its valid is high; otherwise it holds its previous value.
- Ordering: responses return in grant order. A client may keep one read in flight per cycle, with no back-pressure on responses.
- Reset (asynchronous, rst=0):
  - All outputs go to 0: wr, rd, addr_wr, addr_rd, data_wr, cN_rd_valid, cN_rd_data.
  - Pointers go to 0 and the tag pipeline is cleared.
  - In-flight reads are discarded with no valid.
  - gnt outputs are 0 while rst=0.

## Timing
- Cycle T: req and gnt high at posedge T.
- T+1: RAM strobe and address high.
- Read: cN_rd_valid is high in cycle T+1+RAM_latency, i.e. T+1+RD_LAT, which is T+2 for RD_LAT=1.
- Sustained throughput: one write plus one read per cycle, with no bubbles except collision stalls.
- Reset release: the first grant is possible in the first cycle after rst rises. With both clients requesting, client 0 wins first.

## Test plan
- Single write/read, c0:
  - Stimulus: write addr 3 data 0xDEADBEEF, then read addr 3.
  - Response: wr=1 the cycle after gnt. c0_rd_valid at grant+2 with data 0xDEADBEEF, and c1_rd_valid stays 0.
- Round-robin on writes: both clients request writes continuously for 6 cycles.
  - Grants alternate c0,c1,c0,c1,c0,c1.
  - addr_wr follows that order one cycle later.
- Collision: same cycle, c0 writes addr 5 and c1 reads addr 5.
  - c1_rd_gnt=0 that cycle and =1 the next cycle.
  - The read returns the newly written data.
- Interleaved reads: both clients read continuously from addresses 0..7.
  - Each cN_rd_valid matches its own granted address's contents.
  - Valids are never both high in one cycle.
- Reset mid-operation: rst low while two reads are in flight.
  - All outputs 0 immediately, with no rd_valid after release.
  - Pointers reset, so c0 wins the first contested grant.
